// File: rtl/sw_mode_sequencer.sv
// sw_mode_sequencer: debounces SW[1:0] into a run mode and drives a prescaled toggle/pattern output
// Ports: clk, rst (sync, active high); SW raw switches (async); out registered waveform;
//        mode committed mode (0 off, 1 slow toggle, 2 fast toggle, 3 pattern);
//        tick one-cycle prescaler wrap pulse; busy high while debouncing or in SWITCH.
// Optional: define SEQ_STATUS_EN to add tick_count[7:0], saturating ticks since the last SWITCH.
module sw_mode_sequencer #(
  parameter int DEB_CYCLES = 4,
  parameter int DIV_SLOW = 8,
  parameter int DIV_FAST = 2,
  parameter logic [7:0] PATTERN = 8'hB2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] SW,
  output logic       out,
  output logic [1:0] mode,
  output logic       tick,
  output logic       busy
`ifdef SEQ_STATUS_EN
  ,output logic [7:0] tick_count
`endif
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam int DMAX = DIV_SLOW > DIV_FAST ? DIV_SLOW : DIV_FAST;
  localparam int PW = $clog2(DMAX);
  typedef enum logic [1:0] {IDLE, SWITCH, RUN} state_t;
  state_t state_q, state_d;
  logic [1:0] s1_q, sw_s_q, cand_q, cand_d, mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pre_q, pre_d, div_m1;
  logic [2:0] idx_q, idx_d;
  logic out_q, out_d, commit, run;
`ifdef SEQ_STATUS_EN
  logic [7:0] tc_q, tc_d;
  assign tick_count = tc_q;
`endif
  // a value that differs from the committed mode must hold for DEB_CYCLES counts before it commits
  assign commit = cnt_q == CW'(DEB_CYCLES) && sw_s_q == cand_q && sw_s_q != mode_q;
  assign cand_d = (sw_s_q != mode_q && sw_s_q != cand_q) ? sw_s_q : cand_q;
  assign cnt_d = (sw_s_q == mode_q || commit) ? '0 : sw_s_q != cand_q ? CW'(1) : cnt_q + CW'(1);
  assign mode_d = commit ? cand_q : mode_q;
  assign mode = mode_q;
  assign out = out_q;
  always_ff @(posedge clk)
    state_q <= rst ? IDLE : state_d;
  always_comb
    state_d = commit ? SWITCH : state_q == SWITCH ? (mode_q == 2'd0 ? IDLE : RUN) : state_q;
  // a commit forces SWITCH, so it also discards any output update from a coincident tick
  always_comb begin
    run = state_q == RUN;
    div_m1 = mode_q == 2'd1 ? PW'(DIV_SLOW - 1) : PW'(DIV_FAST - 1);
    tick = run && pre_q == div_m1;
    busy = cnt_q != '0 || state_q == SWITCH;
    pre_d = (commit || !run || tick) ? '0 : pre_q + PW'(1);
    idx_d = (commit || !run) ? 3'd0 : (tick && mode_q == 2'd3) ? idx_q + 3'd1 : idx_q;
    out_d = (commit || !run) ? 1'b0 : !tick ? out_q : mode_q == 2'd3 ? PATTERN[idx_q] : ~out_q;
`ifdef SEQ_STATUS_EN
    tc_d = (commit || !run) ? 8'd0 : (tick && tc_q != 8'hFF) ? tc_q + 8'd1 : tc_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      sw_s_q <= '0;
      cand_q <= '0;
      cnt_q <= '0;
      mode_q <= '0;
      pre_q <= '0;
      idx_q <= '0;
      out_q <= 1'b0;
`ifdef SEQ_STATUS_EN
      tc_q <= '0;
`endif
    end else begin
      s1_q <= SW;
      sw_s_q <= s1_q;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      out_q <= out_d;
`ifdef SEQ_STATUS_EN
      tc_q <= tc_d;
`endif
    end
  end
endmodule

// File: doc/sw_mode_sequencer.md
Name: sw_mode_sequencer

Overview:
- Controller that turns the two board switches into a run mode for the blink/divider output path.
- Synchronizes and debounces `SW[1:0]`, then commits a mode.
- Sequences a clean changeover through a one-cycle SWITCH state.
- Drives the prescaler and output generator (toggle or 8-step pattern).
- Sits between the raw switch pins and the LED/output pin.

Parameters:
- DEB_CYCLES, 4: consecutive cycles a synchronized SW value must hold before commit (≥1).
- DIV_SLOW, 8: prescaler period in cycles for mode 1 (≥2).
- DIV_FAST, 2: prescaler period in cycles for modes 2 and 3 (≥2).
- PATTERN, 8'hB2: mode-3 output sequence; bit 0 is emitted first.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- SW, input, 2: raw switch inputs, asynchronous to clk.
- out, output, 1: registered output waveform.
- mode, output, 2: committed mode (0 off, 1 slow toggle, 2 fast toggle, 3 pattern).
- tick, output, 1: one-cycle pulse at each prescaler wrap.
- busy, output, 1: high while a debounce count is in progress or state is SWITCH.

Behaviour:
- Reset (rst=1 at an edge):
  - Synchronizer flops = 0, candidate = 0, debounce count = 0.
  - mode = 0, state = IDLE, prescaler = 0, pattern index = 0.
  - out = 0, tick = 0, busy = 0.
  - rst overrides everything, including mid-debounce or SWITCH; no commit completes on a reset edge.
- Synchronizer: two flops, giving sw_s.
- Debounce:
  - If sw_s == mode: count cleared, busy (debounce part) = 0.
  - Else if sw_s != candidate: candidate <= sw_s, count <= 1.
  - Else: count increments.
  - When count == DEB_CYCLES and sw_s == candidate: mode <= candidate, count <= 0.
- Latency: SW stable from edge k is committed at edge k+2+DEB_CYCLES. Any glitch shorter than DEB_CYCLES cycles never changes mode.
- A bounce back to the current mode before commit cancels the pending change; mode is unchanged and busy drops.
- FSM states:
  - IDLE: mode 0. out = 0, tick = 0, prescaler held at 0.
  - SWITCH: entered on the commit edge from any state, including SWITCH itself. Lasts exactly one cycle. out = 0, tick = 0, prescaler = 0, index = 0. Next state is IDLE if the new mode is 0, else RUN.
  - RUN: prescaler counts 0..DIV-1, where DIV = DIV_SLOW for mode 1 and DIV_FAST for modes 2/3.
- Prescaler and tick in RUN:
  - tick = 1 for the cycle in which the prescaler equals DIV-1; the prescaler then wraps to 0.
  - The first tick occurs DIV cycles after entering RUN.
- Output update, registered on the tick cycle's edge:
  - Modes 1/2: out <= ~out.
  - Mode 3: out <= PATTERN[index], index <= index+1 (wraps 7→0).
  - Before the first tick in mode 3, out = 0.
- Simultaneous events: if a commit occurs on a tick cycle, the commit wins. State goes to SWITCH and the tick's output update is discarded.
- busy = (count != 0) | (state == SWITCH).

Optional Feature:
- Macro: SEQ_STATUS_EN.
- When defined:
  - Adds output `tick_count[7:0]`, counting ticks since the last SWITCH.
  - It saturates at 255, clears to 0 in SWITCH and on reset, and stays 0 in IDLE.
- When undefined:
  - Port and counter are absent.
  - All other behaviour is identical.

Test Plan (defaults):
- Reset then SW=0 for 20 cycles → mode=0, out=0, tick=0, busy=0 throughout.
- SW=1 from edge k → mode=1 at edge k+6; SWITCH for 1 cycle; first tick 8 cycles after RUN entry. out toggles every 8 cycles (period 16).
- SW=3 stable → mode=3. out follows 0,1,0,0,1,1,0,1 (8'hB2, LSB first), one bit per 2-cycle tick, then repeats.
- In mode 2, pulse SW to 1 for 3 cycles, then back to 2 → mode stays 2, no SWITCH, busy high only during the count, out toggling undisturbed.
- In mode 1, change SW to 2 so the commit lands on a tick cycle → SWITCH taken, out=0, prescaler restarts, first mode-2 tick 2 cycles after RUN.
- Assert rst mid-debounce and during SWITCH → all outputs 0 next cycle, mode=0, no commit. With SEQ_STATUS_EN, tick_count=0 after reset and saturates at 255 after ≥255 ticks in mode 2.
